reorder_buffer: RTL and testbench
=================================

REORDER_BUFFER -- requirements
Module: reorder_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 16: entry count, power of two, 4..64.
REQ-002 SHALL have parameter XLEN, default 32: data/PC width.
REQ-003 SHALL have parameter WB_PORTS, default 2: writeback channels (RS, LSB, ...).
REQ-004 SHALL derive IDXW = log2(DEPTH) as tag width.
REQ-005 SHALL have clock `clk` and reset `rst`: one clock; reset is asynchronous and active-high.
REQ-006 SHALL have port: rdy  in  1  global enable; low freezes all state.
REQ-007 SHALL have ports: alloc_valid in 1; alloc_kind in 2 (0 normal, 1 store, 2 branch, 3 jalr); alloc_rd in 5; alloc_pred in 1 (predicted taken); alloc_val in XLEN (precomputed result or alternate PC); alloc_done in 1 (complete at issue).
REQ-008 SHALL have ports: alloc_tag out IDXW (= tail); full out 1; count out IDXW+1.
REQ-009 SHALL have ports: src_tag in 2*IDXW; src_ready out 2; src_val out 2*XLEN.
REQ-010 SHALL have ports: wb_valid in WB_PORTS; wb_tag in WB_PORTS*IDXW; wb_val in WB_PORTS*XLEN.
REQ-011 SHALL have ports: commit_valid out 1; commit_tag out IDXW; commit_rd out 5; commit_val out XLEN; store_go out 1.
REQ-012 SHALL have ports: flush out 1 (registered); redirect_pc out XLEN (registered).

Function
REQ-013 Allocation SHALL occur when alloc_valid && rdy && !full && !flush; entry written at tail, tail += 1 mod DEPTH; entry ready = alloc_done || kind==store.
REQ-014 full SHALL equal (count == DEPTH), combinational from registered count; allocation while full SHALL be dropped, even if a commit occurs that cycle.
REQ-015 count SHALL update as count + alloc - commit each enabled cycle; simultaneous alloc and commit leave it unchanged.
REQ-016 Writeback on port p SHALL set ready and store wb_val for entry wb_tag if busy; writebacks to non-busy tags SHALL be ignored; on same-tag collision the lowest port index wins.
REQ-017 For branch entries wb_val[0] SHALL be the actual-taken bit; mispredict = (bit != alloc_pred); stored alloc_val (alternate PC) retained.
REQ-018 Commit SHALL occur when count>0 && head ready && rdy && !flush: commit_valid=1, head += 1 mod DEPTH; commit_* outputs are combinational from head.
REQ-019 commit_valid SHALL be asserted only for kind normal or jalr with rd != 0; commit of store/branch advances head silently.
REQ-020 store_go SHALL be 1 when count>0 and head kind == store, independent of rdy.
REQ-021 Committing a mispredicted branch SHALL set flush=1 and redirect_pc = alternate PC next cycle.
REQ-022 Committing a jalr SHALL set flush=1 and redirect_pc = its writeback target next cycle.
REQ-023 In the flush cycle, head, tail, count and all busy/ready bits SHALL clear; allocation, writeback and commit ignored; flush deasserts the following cycle.
REQ-024 src_ready/src_val SHALL be combinational: if a same-cycle wb matches src_tag, return that wb_val with ready=1 (bypass); else entry ready and value; if not ready, src_val = zero-extended tag.
REQ-025 Pointer wrap SHALL be natural modulo DEPTH; full vs empty is decided by count only.
REQ-026 With rdy low, all registers SHALL hold, including flush.

Reset
REQ-027 On rst: head=tail=count=0, all busy/ready bits 0, flush=0, redirect_pc=0; entry payload arrays need not reset.
REQ-028 Reset asserted mid-operation SHALL abandon any pending flush and empty the buffer immediately.

Structure
REQ-029 Shared package rob_pkg SHALL hold kind encodings and parameter defaults.
REQ-030 One sub-module rob_src_lookup (tag read plus wb bypass) SHALL be instantiated twice.

Verification
REQ-031 DEPTH=4: allocate 4 with alloc_done=0 -> full=1, count=4; 5th alloc dropped, tail unchanged.
REQ-032 Alloc tag 0 normal rd=5; wb port1 tag 0 val 0x1234 -> next cycle commit_valid, commit_rd=5, commit_val=0x1234.
REQ-033 Branch pred=1, alt PC 0x100; wb val 0 -> at commit, next cycle flush=1, redirect_pc=0x100, count=0.
REQ-034 src_tag=2 while wb port0 tag 2 val 0xABCD same cycle -> src_ready=1, src_val=0xABCD.
REQ-035 Ports 0 and 1 write tag 3 with 0x11/0x22 -> entry value 0x11.
REQ-036 Wrap: 20 alloc/commit pairs at DEPTH=16 -> tags wrap 15->0, count stays ≤1, no spurious full.

Source files
------------

// File: rtl/rob_pkg.sv
// Reorder buffer shared types and defaults.
// Kind encodings follow the alloc_kind port.
package rob_pkg;
  localparam int ROB_DEPTH    = 16;
  localparam int ROB_XLEN     = 32;
  localparam int ROB_WB_PORTS = 2;

  typedef enum logic [1:0] {
    K_NORMAL = 2'd0,
    K_STORE  = 2'd1,
    K_BRANCH = 2'd2,
    K_JALR   = 2'd3
  } kind_e;
endpackage

// File: rtl/rob_src_lookup.sv
// Operand lookup by ROB tag with same-cycle writeback bypass.
// Lowest-numbered writeback port wins on a tag match.
module rob_src_lookup
  import rob_pkg::*;
#(
  parameter int DEPTH    = ROB_DEPTH,
  parameter int XLEN     = ROB_XLEN,
  parameter int WB_PORTS = ROB_WB_PORTS,
  parameter int IDXW     = $clog2(DEPTH)
) (
  input  logic [IDXW-1:0]          i_tag,
  input  logic [WB_PORTS-1:0]      i_wb_valid,
  input  logic [WB_PORTS*IDXW-1:0] i_wb_tag,
  input  logic [WB_PORTS*XLEN-1:0] i_wb_val,
  input  logic [DEPTH-1:0]         i_ready,
  input  logic [XLEN-1:0]          i_val,
  output logic                     o_ready,
  output logic [XLEN-1:0]          o_val
);

  always_comb begin
    o_ready = i_ready[i_tag];
    o_val   = o_ready ? i_val : XLEN'(i_tag);
    for (int p = WB_PORTS - 1; p >= 0; p--) begin
      if (i_wb_valid[p] && i_wb_tag[p*IDXW +: IDXW] == i_tag) begin
        o_ready = 1'b1;
        o_val   = i_wb_val[p*XLEN +: XLEN];
      end
    end
  end

endmodule

// File: rtl/reorder_buffer.sv
// Circular reorder buffer: in-order commit, branch/jalr flush,
// multi-port writeback and two bypassed operand lookups.
module reorder_buffer
  import rob_pkg::*;
#(
  parameter int DEPTH    = ROB_DEPTH,
  parameter int XLEN     = ROB_XLEN,
  parameter int WB_PORTS = ROB_WB_PORTS,
  localparam int IDXW    = $clog2(DEPTH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     rdy,
  input  logic                     alloc_valid,
  input  logic [1:0]               alloc_kind,
  input  logic [4:0]               alloc_rd,
  input  logic                     alloc_pred,
  input  logic [XLEN-1:0]          alloc_val,
  input  logic                     alloc_done,
  output logic [IDXW-1:0]          alloc_tag,
  output logic                     full,
  output logic [IDXW:0]            count,
  input  logic [2*IDXW-1:0]        src_tag,
  output logic [1:0]               src_ready,
  output logic [2*XLEN-1:0]        src_val,
  input  logic [WB_PORTS-1:0]      wb_valid,
  input  logic [WB_PORTS*IDXW-1:0] wb_tag,
  input  logic [WB_PORTS*XLEN-1:0] wb_val,
  output logic                     commit_valid,
  output logic [IDXW-1:0]          commit_tag,
  output logic [4:0]               commit_rd,
  output logic [XLEN-1:0]          commit_val,
  output logic                     store_go,
  output logic                     flush,
  output logic [XLEN-1:0]          redirect_pc
);

  localparam int CW = IDXW + 1;

  logic [IDXW-1:0]  r_head;
  logic [IDXW-1:0]  r_tail;
  logic [CW-1:0]    r_count;
  logic [DEPTH-1:0] r_busy;
  logic [DEPTH-1:0] r_ready;
  logic [DEPTH-1:0] r_mis;
  logic [DEPTH-1:0] r_pred;
  kind_e            r_kind [DEPTH];
  logic [4:0]       r_rd   [DEPTH];
  logic [XLEN-1:0]  r_val  [DEPTH];
  logic             r_flush;
  logic [XLEN-1:0]  r_redirect;

  logic                w_alloc;
  logic                w_commit;
  logic                w_empty;
  logic                w_redir;
  kind_e               w_hk;
  logic [IDXW-1:0]     w_wbt [WB_PORTS];
  logic [XLEN-1:0]     w_wbv [WB_PORTS];
  logic [WB_PORTS-1:0] w_wbhit;

  for (genvar p = 0; p < WB_PORTS; p++) begin : g_wb
    assign w_wbt[p]   = wb_tag[p*IDXW +: IDXW];
    assign w_wbv[p]   = wb_val[p*XLEN +: XLEN];
    assign w_wbhit[p] = wb_valid[p] && r_busy[w_wbt[p]];
  end

  assign w_hk     = r_kind[r_head];
  assign w_empty  = (r_count == '0);
  assign full     = (r_count == CW'(DEPTH));
  assign w_alloc  = alloc_valid && rdy && !full && !r_flush;
  assign w_commit = !w_empty && r_ready[r_head] && rdy && !r_flush;
  assign w_redir  = (w_hk == K_JALR) ||
                    (w_hk == K_BRANCH && r_mis[r_head]);

  assign alloc_tag    = r_tail;
  assign count        = r_count;
  assign commit_tag   = r_head;
  assign commit_rd    = r_rd[r_head];
  assign commit_val   = r_val[r_head];
  assign commit_valid = w_commit && r_rd[r_head] != 5'd0 &&
                        (w_hk == K_NORMAL || w_hk == K_JALR);
  assign store_go     = !w_empty && w_hk == K_STORE;
  assign flush        = r_flush;
  assign redirect_pc  = r_redirect;

  // Payload needs no reset; busy/ready gate every use of it.
  always_ff @(posedge clk) begin
    if (rdy && !r_flush) begin
      for (int p = WB_PORTS - 1; p >= 0; p--) begin
        if (w_wbhit[p]) begin
          if (r_kind[w_wbt[p]] == K_BRANCH)
            r_mis[w_wbt[p]] <= w_wbv[p][0] != r_pred[w_wbt[p]];
          else
            r_val[w_wbt[p]] <= w_wbv[p];
        end
      end
      if (w_alloc) begin
        r_kind[r_tail] <= kind_e'(alloc_kind);
        r_rd[r_tail]   <= alloc_rd;
        r_pred[r_tail] <= alloc_pred;
        r_val[r_tail]  <= alloc_val;
        r_mis[r_tail]  <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
      r_busy     <= '0;
      r_ready    <= '0;
      r_flush    <= 1'b0;
      r_redirect <= '0;
    end else if (rdy) begin
      if (r_flush) begin
        r_head  <= '0;
        r_tail  <= '0;
        r_count <= '0;
        r_busy  <= '0;
        r_ready <= '0;
        r_flush <= 1'b0;
      end else begin
        for (int p = 0; p < WB_PORTS; p++)
          if (w_wbhit[p]) r_ready[w_wbt[p]] <= 1'b1;
        if (w_commit) begin
          r_busy[r_head]  <= 1'b0;
          r_ready[r_head] <= 1'b0;
          r_head          <= r_head + 1'b1;
          if (w_redir) begin
            r_flush    <= 1'b1;
            r_redirect <= r_val[r_head];
          end
        end
        if (w_alloc) begin
          r_busy[r_tail]  <= 1'b1;
          r_ready[r_tail] <= alloc_done || alloc_kind == K_STORE;
          r_tail          <= r_tail + 1'b1;
        end
        r_count <= r_count + CW'(w_alloc) - CW'(w_commit);
      end
    end
  end

  for (genvar s = 0; s < 2; s++) begin : g_src
    rob_src_lookup #(
      .DEPTH(DEPTH), .XLEN(XLEN),
      .WB_PORTS(WB_PORTS), .IDXW(IDXW)
    ) u_src (
      .i_tag      (src_tag[s*IDXW +: IDXW]),
      .i_wb_valid (wb_valid),
      .i_wb_tag   (wb_tag),
      .i_wb_val   (wb_val),
      .i_ready    (r_ready),
      .i_val      (r_val[src_tag[s*IDXW +: IDXW]]),
      .o_ready    (src_ready[s]),
      .o_val      (src_val[s*XLEN +: XLEN])
    );
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench: DEPTH=4 instance for function, DEPTH=16 for wrap.
module tb_reorder_buffer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_tot = 0;
  int n_bad = 0;

  // DEPTH=4 instance
  logic        rdy = 1'b1;
  logic        av = 1'b0;
  logic [1:0]  ak = 2'd0;
  logic [4:0]  ard = 5'd0;
  logic        apred = 1'b0;
  logic [31:0] aval = '0;
  logic        adone = 1'b0;
  logic [1:0]  atag;
  logic        full;
  logic [2:0]  count;
  logic [3:0]  stag = '0;
  logic [1:0]  srdy;
  logic [63:0] sval;
  logic [1:0]  wv = '0;
  logic [3:0]  wt = '0;
  logic [63:0] wd = '0;
  logic        cv;
  logic [1:0]  ctag;
  logic [4:0]  crd;
  logic [31:0] cval;
  logic        sgo;
  logic        fl;
  logic [31:0] rpc;

  reorder_buffer #(.DEPTH(4), .XLEN(32), .WB_PORTS(2)) dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .alloc_valid(av), .alloc_kind(ak), .alloc_rd(ard),
    .alloc_pred(apred), .alloc_val(aval), .alloc_done(adone),
    .alloc_tag(atag), .full(full), .count(count),
    .src_tag(stag), .src_ready(srdy), .src_val(sval),
    .wb_valid(wv), .wb_tag(wt), .wb_val(wd),
    .commit_valid(cv), .commit_tag(ctag), .commit_rd(crd),
    .commit_val(cval), .store_go(sgo),
    .flush(fl), .redirect_pc(rpc)
  );

  // DEPTH=16 instance
  logic        b_av = 1'b0;
  logic [3:0]  b_atag;
  logic        b_full;
  logic [4:0]  b_count;
  logic [1:0]  b_srdy;
  logic [63:0] b_sval;
  logic        b_cv;
  logic [3:0]  b_ctag;
  logic [4:0]  b_crd;
  logic [31:0] b_cval;
  logic        b_sgo;
  logic        b_fl;
  logic [31:0] b_rpc;

  reorder_buffer #(.DEPTH(16), .XLEN(32), .WB_PORTS(2)) dut16 (
    .clk(clk), .rst(rst), .rdy(1'b1),
    .alloc_valid(b_av), .alloc_kind(2'd0), .alloc_rd(5'd1),
    .alloc_pred(1'b0), .alloc_val(32'h0), .alloc_done(1'b1),
    .alloc_tag(b_atag), .full(b_full), .count(b_count),
    .src_tag(8'h0), .src_ready(b_srdy), .src_val(b_sval),
    .wb_valid(2'b00), .wb_tag(8'h0), .wb_val(64'h0),
    .commit_valid(b_cv), .commit_tag(b_ctag), .commit_rd(b_crd),
    .commit_val(b_cval), .store_go(b_sgo),
    .flush(b_fl), .redirect_pc(b_rpc)
  );

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic alloc(input logic [1:0] k, input logic [4:0] rd,
                       input logic p, input logic [31:0] v,
                       input logic d);
    av = 1'b1; ak = k; ard = rd; apred = p; aval = v; adone = d;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

  initial begin
    tick();
    tick();
    chk("rst_cnt", count, 0);
    chk("rst_full", full, 0);
    chk("rst_flush", fl, 0);
    chk("rst_rpc", rpc, 0);
    chk("rst_cv", cv, 0);
    chk("rst_atag", atag, 0);
    chk("rst_sgo", sgo, 0);
    rst = 1'b0;
    tick();

    // fill four, fifth dropped
    for (int i = 0; i < 4; i++) begin
      alloc(2'd0, 5'(5 + i), 1'b0, 32'h0, 1'b0);
      #1;
      chk("fill_atag", atag, i);
      tick();
    end
    #1;
    chk("full", full, 1);
    chk("full_cnt", count, 4);
    tick();
    av = 1'b0;
    chk("drop_cnt", count, 4);
    chk("drop_atag", atag, 0);

    // bypass on slot0, not-ready tag on slot1
    stag = {2'd1, 2'd2};
    wv = 2'b01; wt = {2'd0, 2'd2}; wd = {32'h0, 32'hABCD};
    #1;
    chk("byp_rdy0", srdy[0], 1);
    chk("byp_val0", sval[31:0], 32'hABCD);
    chk("nrdy_rdy1", srdy[1], 0);
    chk("nrdy_val1", sval[63:32], 1);
    tick();
    wv = 2'b00;
    #1;
    chk("ent_rdy", srdy[0], 1);
    chk("ent_val", sval[31:0], 32'hABCD);

    // same-tag collision
    wv = 2'b11; wt = {2'd3, 2'd3}; wd = {32'h22, 32'h11};
    tick();
    wv = 2'b00; stag = {2'd1, 2'd3};
    #1;
    chk("coll_rdy", srdy[0], 1);
    chk("coll_val", sval[31:0], 32'h11);

    // commit head, alloc while full is dropped
    wv = 2'b10; wt = {2'd0, 2'd0}; wd = {32'h1234, 32'h0};
    tick();
    wv = 2'b00;
    alloc(2'd0, 5'd9, 1'b0, 32'h0, 1'b1);
    #1;
    chk("c0_valid", cv, 1);
    chk("c0_rd", crd, 5);
    chk("c0_val", cval, 32'h1234);
    chk("c0_tag", ctag, 0);
    tick();
    av = 1'b0;
    #1;
    chk("c0_cnt", count, 3);
    chk("c0_atag", atag, 0);
    chk("c0_full", full, 0);
    chk("c1_wait", cv, 0);

    // rdy low freezes commit
    wv = 2'b01; wt = {2'd0, 2'd1}; wd = {32'h0, 32'h55};
    tick();
    wv = 2'b00; rdy = 1'b0;
    #1;
    chk("frz_cv", cv, 0);
    tick();
    chk("frz_cnt", count, 3);
    rdy = 1'b1;
    #1;
    chk("c1_valid", cv, 1);
    chk("c1_rd", crd, 6);
    chk("c1_val", cval, 32'h55);
    tick();
    chk("c2_rd", crd, 7);
    chk("c2_val", cval, 32'hABCD);
    tick();
    chk("c3_rd", crd, 8);
    chk("c3_val", cval, 32'h11);
    tick();
    chk("drain_cnt", count, 0);
    chk("drain_cv", cv, 0);

    // mispredicted branch
    alloc(2'd2, 5'd0, 1'b1, 32'h100, 1'b0);
    #1;
    chk("br_atag", atag, 0);
    tick();
    av = 1'b0;
    wv = 2'b01; wt = 4'd0; wd = 64'h0;
    tick();
    wv = 2'b00;
    #1;
    chk("br_cv", cv, 0);
    chk("br_sgo", sgo, 0);
    tick();
    chk("br_flush", fl, 1);
    chk("br_rpc", rpc, 32'h100);
    chk("br_cnt", count, 0);
    rdy = 1'b0;
    tick();
    chk("fl_hold", fl, 1);
    rdy = 1'b1;
    alloc(2'd0, 5'd1, 1'b0, 32'h0, 1'b1);
    tick();
    av = 1'b0;
    chk("fl_end", fl, 0);
    chk("fl_cnt", count, 0);
    chk("fl_atag", atag, 0);

    // store at head
    alloc(2'd1, 5'd0, 1'b0, 32'h0, 1'b0);
    tick();
    av = 1'b0; rdy = 1'b0;
    #1;
    chk("st_go", sgo, 1);
    chk("st_cv", cv, 0);
    tick();
    rdy = 1'b1;
    #1;
    chk("st_cnt", count, 1);
    tick();
    chk("st_done", count, 0);
    chk("st_go0", sgo, 0);

    // jalr redirect to writeback target
    alloc(2'd3, 5'd1, 1'b0, 32'h0, 1'b0);
    #1;
    chk("j_atag", atag, 1);
    tick();
    av = 1'b0;
    wv = 2'b10; wt = {2'd1, 2'd0}; wd = {32'h2000, 32'h0};
    tick();
    wv = 2'b00;
    #1;
    chk("j_cv", cv, 1);
    chk("j_val", cval, 32'h2000);
    chk("j_tag", ctag, 1);
    tick();
    chk("j_flush", fl, 1);
    chk("j_rpc", rpc, 32'h2000);
    tick();
    chk("j_end", fl, 0);

    // writeback to idle tag ignored
    wv = 2'b01; wt = {2'd0, 2'd2}; wd = {32'h0, 32'h77};
    tick();
    wv = 2'b00; stag = {2'd1, 2'd2};
    #1;
    chk("idle_rdy", srdy[0], 0);
    chk("idle_val", sval[31:0], 2);

    // async reset during pending flush
    alloc(2'd3, 5'd1, 1'b0, 32'h300, 1'b1);
    tick();
    av = 1'b0;
    tick();
    chk("ra_flush", fl, 1);
    rst = 1'b1;
    #1;
    chk("ra_fl0", fl, 0);
    chk("ra_cnt", count, 0);
    chk("ra_rpc", rpc, 0);
    rst = 1'b0;
    tick();

    // wrap at DEPTH=16
    for (int i = 0; i < 20; i++) begin
      b_av = 1'b1;
      #1;
      chk("w_atag", b_atag, i % 16);
      chk("w_cnt", b_count <= 5'd1, 1);
      chk("w_full", b_full, 0);
      if (i > 0) begin
        chk("w_cv", b_cv, 1);
        chk("w_ctag", b_ctag, (i - 1) % 16);
      end
      tick();
    end
    b_av = 1'b0;
    #1;
    chk("w_last", b_ctag, 3);
    tick();
    chk("w_empty", b_count, 0);

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end
endmodule
